reg_bank_8_write_port: RTL and testbench

Write-side companion of the 8-to-1 N-bit read mux. Holds eight N-bit registers R0..R7, whose outputs feed the read mux's A..H inputs directly. Decodes a 3-bit write address (1-to-8 demux) under a valid/ready handshake, with per-register write protect, dirty tracking, and a sequenced clear-all sweep. Sits in the datapath between the ALU/bus write-back and the register read mux.

---
 rtl/reg_bank_pkg.sv | 12 +
 rtl/reg_bank_8_write_port_decoder.sv | 15 +
 rtl/reg_bank_8_write_port.sv | 128 ++++++++++++
 tb/tb_reg_bank_8_write_port.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/reg_bank_pkg.sv
// Shared types and sizes for the 8-entry write-side register bank.
package reg_bank_pkg;

  localparam int unsigned NUM_REGS = 8;
  localparam int unsigned ADDR_W   = 3;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } bank_state_t;

endpackage

// File: rtl/reg_bank_8_write_port_decoder.sv
// 1-of-8 address decoder producing a one-hot write strobe when enabled.
module decoder_3_to_8
  import reg_bank_pkg::*;
(
  input  logic [ADDR_W-1:0]   addr,
  input  logic                en,
  output logic [NUM_REGS-1:0] strobe_c
);

  always_comb begin
    strobe_c = '0;
    if (en) strobe_c[addr] = 1'b1;
  end

endmodule

// File: rtl/reg_bank_8_write_port.sv
// Eight N-bit registers with handshaked, protectable writes, dirty tracking
// and a one-register-per-cycle clear-all sweep.
module reg_bank_8_write_port
  import reg_bank_pkg::*;
#(
  parameter int unsigned N = 16
) (
  input  logic          Clock,
  input  logic          Resetn,
  input  logic          WrValid,
  output logic          WrReady,
  input  logic [2:0]    WrAddr,
  input  logic [N-1:0]  WrData,
  input  logic [7:0]    WrProt,
  input  logic          ClearReq,
  output logic          ClearBusy,
  output logic          ClrDone,
  output logic          WrAck,
  output logic          WrErr,
  output logic [7:0]    Dirty,
  output logic [N-1:0]  R0,
  output logic [N-1:0]  R1,
  output logic [N-1:0]  R2,
  output logic [N-1:0]  R3,
  output logic [N-1:0]  R4,
  output logic [N-1:0]  R5,
  output logic [N-1:0]  R6,
  output logic [N-1:0]  R7
);

  bank_state_t         state;
  bank_state_t         state_nxt;
  logic [ADDR_W-1:0]   cnt;
  logic [N-1:0]        regs [NUM_REGS];
  logic [NUM_REGS-1:0] dirty_q;
  logic [NUM_REGS-1:0] wr_strb;
  logic [NUM_REGS-1:0] clr_strb;

  logic ready_int;
  logic accept;
  logic prot_hit;
  logic wr_en;
  logic sweep_en;
  logic sweep_last;

  // Handshake and write qualification
  assign ready_int  = (state == IDLE) && !ClearReq;
  assign accept     = WrValid && ready_int;
  assign prot_hit   = WrProt[WrAddr];
  assign wr_en      = accept && !prot_hit;
  assign sweep_en   = (state == CLEAR);
  assign sweep_last = sweep_en && (cnt == ADDR_W'(NUM_REGS - 1));

  assign WrReady   = ready_int;
  assign ClearBusy = sweep_en;

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) state <= IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (ClearReq) state_nxt = CLEAR;
      CLEAR:   if (sweep_last) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Sweep index restarts at zero every time CLEAR is entered
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn)       cnt <= '0;
    else if (sweep_en) cnt <= cnt + ADDR_W'(1);
    else               cnt <= '0;
  end

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      WrAck   <= 1'b0;
      WrErr   <= 1'b0;
      ClrDone <= 1'b0;
    end else begin
      WrAck   <= wr_en;
      WrErr   <= accept && prot_hit;
      ClrDone <= sweep_last;
    end
  end

  decoder_3_to_8 u_wr_dec (
    .addr     (WrAddr),
    .en       (wr_en),
    .strobe_c (wr_strb)
  );

  decoder_3_to_8 u_clr_dec (
    .addr     (cnt),
    .en       (sweep_en),
    .strobe_c (clr_strb)
  );

  // Sweep and write strobes are mutually exclusive by FSM state
  for (genvar k = 0; k < NUM_REGS; k++) begin : g_reg
    always_ff @(posedge Clock or negedge Resetn) begin
      if (!Resetn) begin
        regs[k]    <= '0;
        dirty_q[k] <= 1'b0;
      end else if (clr_strb[k]) begin
        regs[k]    <= '0;
        dirty_q[k] <= 1'b0;
      end else if (wr_strb[k]) begin
        regs[k]    <= WrData;
        dirty_q[k] <= 1'b1;
      end
    end
  end

  assign Dirty = dirty_q;
  assign R0 = regs[0];
  assign R1 = regs[1];
  assign R2 = regs[2];
  assign R3 = regs[3];
  assign R4 = regs[4];
  assign R5 = regs[5];
  assign R6 = regs[6];
  assign R7 = regs[7];

endmodule

// File: tb/tb_reg_bank_8_write_port.sv
// Directed scoreboard bench for reg_bank_8_write_port.
module tb_reg_bank_8_write_port;

  localparam int unsigned N = 16;

  logic         Clock;
  logic         Resetn;
  logic         WrValid;
  logic         WrReady;
  logic [2:0]   WrAddr;
  logic [N-1:0] WrData;
  logic [7:0]   WrProt;
  logic         ClearReq;
  logic         ClearBusy;
  logic         ClrDone;
  logic         WrAck;
  logic         WrErr;
  logic [7:0]   Dirty;
  logic [N-1:0] R0, R1, R2, R3, R4, R5, R6, R7;
  logic [7:0][N-1:0] r_obs;

  assign r_obs = {R7, R6, R5, R4, R3, R2, R1, R0};

  reg_bank_8_write_port #(.N(N)) dut (
    .Clock(Clock), .Resetn(Resetn),
    .WrValid(WrValid), .WrReady(WrReady), .WrAddr(WrAddr), .WrData(WrData),
    .WrProt(WrProt), .ClearReq(ClearReq), .ClearBusy(ClearBusy), .ClrDone(ClrDone),
    .WrAck(WrAck), .WrErr(WrErr), .Dirty(Dirty),
    .R0(R0), .R1(R1), .R2(R2), .R3(R3), .R4(R4), .R5(R5), .R6(R6), .R7(R7)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  typedef struct packed {
    logic [7:0][N-1:0] regs;
    logic [7:0]        dirty;
    logic              busy;
    logic              ack;
    logic              err;
    logic              done;
  } exp_t;

  exp_t sb[$];

  logic [7:0][N-1:0] m_regs;
  logic [7:0]        m_dirty;
  logic              m_busy;
  logic [2:0]        m_cnt;

  int tests = 0;
  int fails = 0;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_regs  = '0;
    m_dirty = '0;
    m_busy  = 1'b0;
    m_cnt   = '0;
    sb.delete();
  endtask

  // Drive one cycle, predict the post-edge state, then compare after the edge
  task automatic cycle(input logic v, input logic [2:0] a, input logic [N-1:0] d,
                       input logic [7:0] prot, input logic clr);
    exp_t e;
    WrValid  = v;
    WrAddr   = a;
    WrData   = d;
    WrProt   = prot;
    ClearReq = clr;
    #1;
    chk("wr_ready", 128'(WrReady), 128'(!m_busy && !clr));
    e = '0;
    if (!m_busy) begin
      if (clr) begin
        m_busy = 1'b1;
        m_cnt  = 3'd0;
      end else if (v) begin
        if (prot[a]) e.err = 1'b1;
        else begin
          m_regs[a]  = d;
          m_dirty[a] = 1'b1;
          e.ack      = 1'b1;
        end
      end
    end else begin
      m_regs[m_cnt]  = '0;
      m_dirty[m_cnt] = 1'b0;
      if (m_cnt == 3'd7) begin
        m_busy = 1'b0;
        e.done = 1'b1;
      end
      m_cnt = m_cnt + 3'd1;
    end
    e.regs  = m_regs;
    e.dirty = m_dirty;
    e.busy  = m_busy;
    sb.push_back(e);
    @(posedge Clock);
    #1;
    if (sb.size() == 0) begin
      chk("sb_empty", 128'(1), 128'(0));
    end else begin
      e = sb.pop_front();
      chk("regs",       128'(r_obs),     128'(e.regs));
      chk("dirty",      128'(Dirty),     128'(e.dirty));
      chk("clear_busy", 128'(ClearBusy), 128'(e.busy));
      chk("wr_ack",     128'(WrAck),     128'(e.ack));
      chk("wr_err",     128'(WrErr),     128'(e.err));
      chk("clr_done",   128'(ClrDone),   128'(e.done));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    Resetn   = 1'b0;
    WrValid  = 1'b0;
    WrAddr   = '0;
    WrData   = '0;
    WrProt   = '0;
    ClearReq = 1'b0;
    model_reset();
    #12;
    chk("rst_regs",  128'(r_obs),     128'(0));
    chk("rst_dirty", 128'(Dirty),     128'(0));
    chk("rst_ack",   128'(WrAck),     128'(0));
    chk("rst_err",   128'(WrErr),     128'(0));
    chk("rst_done",  128'(ClrDone),   128'(0));
    Resetn = 1'b1;
    #1;
    chk("rst_busy",  128'(ClearBusy), 128'(0));
    chk("rst_ready", 128'(WrReady),   128'(1));
    @(posedge Clock);
    #1;

    // Back-to-back write sweep over every address
    for (int k = 0; k < 8; k++) cycle(1'b1, 3'(k), N'(k * 16'h1111), 8'h00, 1'b0);
    for (int k = 0; k < 8; k++) chk("sweep_val", 128'(r_obs[k]), 128'(N'(k * 16'h1111)));
    chk("sweep_dirty", 128'(Dirty), 128'(8'hFF));

    // Protected write is rejected
    cycle(1'b1, 3'd3, 16'hBEEF, 8'h08, 1'b0);
    chk("prot_r3",  128'(R3),    128'(16'h3333));
    chk("prot_err", 128'(WrErr), 128'(1));
    cycle(1'b0, 3'd0, '0, 8'h00, 1'b0);

    // Clear sweep ignores full protection
    cycle(1'b0, 3'd0, '0, 8'hFF, 1'b1);
    for (int i = 0; i < 8; i++) begin
      cycle(1'b0, 3'd0, '0, 8'hFF, 1'b0);
      chk("clr_step", 128'(r_obs[i]), 128'(0));
    end
    chk("clr_done_pulse", 128'(ClrDone), 128'(1));
    chk("clr_dirty",      128'(Dirty),   128'(0));
    cycle(1'b0, 3'd0, '0, 8'h00, 1'b0);

    // Clear wins over a simultaneous write; held write lands after the sweep
    cycle(1'b1, 3'd2, 16'hAAAA, 8'h00, 1'b0);
    cycle(1'b1, 3'd5, 16'h5555, 8'h00, 1'b0);
    cycle(1'b1, 3'd5, 16'h1234, 8'h00, 1'b1);
    for (int i = 0; i < 8; i++) cycle(1'b1, 3'd5, 16'h1234, 8'h00, 1'b0);
    cycle(1'b1, 3'd5, 16'h1234, 8'h00, 1'b0);
    chk("coll_r5",  128'(R5),    128'(16'h1234));
    chk("coll_r2",  128'(R2),    128'(0));
    chk("coll_ack", 128'(WrAck), 128'(1));
    cycle(1'b0, 3'd0, '0, 8'h00, 1'b0);

    // Last write to the same address wins
    cycle(1'b1, 3'd7, 16'h0F0F, 8'h00, 1'b0);
    cycle(1'b1, 3'd7, 16'hF00D, 8'h00, 1'b0);
    chk("last_wins", 128'(R7), 128'(16'hF00D));

    // Reset in the middle of a sweep
    cycle(1'b1, 3'd6, 16'hCAFE, 8'h00, 1'b0);
    cycle(1'b0, 3'd0, '0, 8'h00, 1'b1);
    for (int i = 0; i < 3; i++) cycle(1'b0, 3'd0, '0, 8'h00, 1'b0);
    Resetn = 1'b0;
    #2;
    model_reset();
    chk("mid_rst_regs",  128'(r_obs),     128'(0));
    chk("mid_rst_busy",  128'(ClearBusy), 128'(0));
    chk("mid_rst_dirty", 128'(Dirty),     128'(0));
    #2;
    Resetn = 1'b1;
    @(posedge Clock);
    #1;
    chk("mid_rst_ready", 128'(WrReady), 128'(1));
    chk("mid_rst_done",  128'(ClrDone), 128'(0));
    cycle(1'b0, 3'd0, '0, 8'h00, 1'b0);
    cycle(1'b1, 3'd4, 16'h4444, 8'h00, 1'b0);
    chk("post_rst_r4", 128'(R4), 128'(16'h4444));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
